// File: rtl/pmem_arbiter.sv
// Arbitrates line-sized read/write requests from NUM_CH cache channels onto a
// single physical memory port, one transaction at a time.
module pmem_arbiter #(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 16,
    parameter int LINE_W   = 128,
    parameter int ARB_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_address,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic                     pmem_read,
    output logic                     pmem_write,
    output logic [ADDR_W-1:0]        pmem_address,
    output logic [LINE_W-1:0]        pmem_wdata,
    input  logic                     pmem_resp,
    input  logic [LINE_W-1:0]        pmem_rdata
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]        state;
    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  winner;
    logic              found;
    logic              op_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [NUM_CH-1:0] req;

    assign req = ch_read | ch_write;

    // Round-robin starts one past the last grant and wraps; fixed mode scans from 0.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ARB_MODE == 1) idx = k;
            else               idx = (int'(last_grant) + 1 + k) % NUM_CH;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_q    <= '0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            last_grant <= IDX_W'(NUM_CH - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state      <= BUSY;
                        grant_q    <= winner;
                        op_write_q <= ch_write[winner];
                        addr_q     <= ch_address[int'(winner)*ADDR_W +: ADDR_W];
                        wdata_q    <= ch_wdata[int'(winner)*LINE_W +: LINE_W];
                        last_grant <= winner;
                    end
                end
                BUSY: begin
                    if (pmem_resp) state <= IDLE;
                end
            endcase
        end
    end

    // Memory side is driven purely from the latched request so it holds until pmem_resp.
    assign pmem_read    = (state == BUSY) && !op_write_q;
    assign pmem_write   = (state == BUSY) &&  op_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign ch_rdata     = pmem_rdata;

    always_comb begin
        ch_resp = '0;
        if (state == BUSY && pmem_resp) ch_resp[grant_q] = 1'b1;
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: a round-robin and a fixed-priority instance
// share one stimulus stream; each step checks against hand-computed values.
module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   ch_read;
    logic [1:0]   ch_write;
    logic [31:0]  ch_address;
    logic [255:0] ch_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;

    logic [1:0]   rr_ch_resp, fp_ch_resp;
    logic [127:0] rr_ch_rdata, fp_ch_rdata;
    logic         rr_read, rr_write, fp_read, fp_write;
    logic [15:0]  rr_addr, fp_addr;
    logic [127:0] rr_wdata, fp_wdata;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] RDATA = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    localparam logic [127:0] A5    = {16{8'hA5}};

    pmem_arbiter #(.NUM_CH(2), .ADDR_W(16), .LINE_W(128), .ARB_MODE(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .ch_read(ch_read), .ch_write(ch_write),
        .ch_address(ch_address), .ch_wdata(ch_wdata), .ch_resp(rr_ch_resp),
        .ch_rdata(rr_ch_rdata), .pmem_read(rr_read), .pmem_write(rr_write),
        .pmem_address(rr_addr), .pmem_wdata(rr_wdata), .pmem_resp(pmem_resp),
        .pmem_rdata(pmem_rdata)
    );

    pmem_arbiter #(.NUM_CH(2), .ADDR_W(16), .LINE_W(128), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .ch_read(ch_read), .ch_write(ch_write),
        .ch_address(ch_address), .ch_wdata(ch_wdata), .ch_resp(fp_ch_resp),
        .ch_rdata(fp_ch_rdata), .pmem_read(fp_read), .pmem_write(fp_write),
        .pmem_address(fp_addr), .pmem_wdata(fp_wdata), .pmem_resp(pmem_resp),
        .pmem_rdata(pmem_rdata)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        ch_read    = '0;
        ch_write   = '0;
        ch_address = '0;
        ch_wdata   = '0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        #3;
        chk("rst_rr_read",  rr_read,    0);
        chk("rst_rr_write", rr_write,   0);
        chk("rst_rr_addr",  rr_addr,    0);
        chk("rst_rr_wdata", rr_wdata,   0);
        chk("rst_rr_resp",  rr_ch_resp, 0);
        chk("rst_fp_read",  fp_read,    0);
        tick();
        rst_n = 1'b1;

        // Single read on channel 1, three busy cycles
        ch_read = 2'b10;
        ch_address[31:16] = 16'h1230;
        tick();
        settle();
        chk("rd_c1_read",  rr_read,    1);
        chk("rd_c1_write", rr_write,   0);
        chk("rd_c1_addr",  rr_addr,    16'h1230);
        chk("rd_c1_resp0", rr_ch_resp, 0);
        tick();
        chk("rd_c2_read",  rr_read,    1);
        tick();
        pmem_resp  = 1'b1;
        pmem_rdata = RDATA;
        ch_read    = 2'b00;
        settle();
        chk("rd_c3_read",  rr_read,     1);
        chk("rd_resp",     rr_ch_resp,  2'b10);
        chk("rd_rdata",    rr_ch_rdata, RDATA);
        tick();
        pmem_resp = 1'b0;
        settle();
        chk("rd_done_read", rr_read,    0);
        chk("rd_done_resp", rr_ch_resp, 0);

        // pmem_resp while idle must not produce a pulse
        pmem_resp = 1'b1;
        settle();
        chk("idle_resp_rr", rr_ch_resp, 0);
        chk("idle_resp_fp", fp_ch_resp, 0);
        tick();
        chk("idle_read", rr_read, 0);
        pmem_resp = 1'b0;

        // Read+write on channel 0 is a write; address/data held while busy
        ch_read  = 2'b01;
        ch_write = 2'b01;
        ch_address[15:0] = 16'h0040;
        ch_wdata[127:0]  = A5;
        tick();
        settle();
        chk("wr_write", rr_write, 1);
        chk("wr_read",  rr_read,  0);
        chk("wr_addr",  rr_addr,  16'h0040);
        chk("wr_wdata", rr_wdata, A5);
        ch_address[15:0] = 16'h9999;
        ch_wdata[127:0]  = '0;
        ch_read  = 2'b00;
        ch_write = 2'b00;
        settle();
        chk("wr_hold_addr",  rr_addr,  16'h0040);
        chk("wr_hold_wdata", rr_wdata, A5);
        tick();
        chk("wr_drop_write", rr_write, 1);
        chk("wr_drop_addr",  rr_addr,  16'h0040);
        pmem_resp = 1'b1;
        settle();
        chk("wr_resp", rr_ch_resp, 2'b01);
        tick();
        pmem_resp = 1'b0;
        settle();
        chk("wr_done_write", rr_write, 0);

        // Reset asserted mid-transaction abandons it
        ch_read = 2'b10;
        ch_address[31:16] = 16'h2000;
        tick();
        chk("mid_busy_read", rr_read, 1);
        chk("mid_busy_addr", rr_addr, 16'h2000);
        rst_n     = 1'b0;
        pmem_resp = 1'b1;
        settle();
        chk("mid_rst_read", rr_read,    0);
        chk("mid_rst_resp", rr_ch_resp, 0);
        chk("mid_rst_addr", rr_addr,    0);
        pmem_resp = 1'b0;
        ch_read = 2'b11;
        ch_address = {16'h0200, 16'h0100};
        tick();
        chk("rst_hold_read", rr_read, 0);
        rst_n = 1'b1;

        // Continuous contention: round-robin alternates, fixed always picks 0
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("cont_rr_read", rr_read, 1);
            chk("cont_rr_addr", rr_addr, (k % 2 == 0) ? 16'h0100 : 16'h0200);
            chk("cont_fp_addr", fp_addr, 16'h0100);
            pmem_resp = 1'b1;
            settle();
            chk("cont_rr_resp", rr_ch_resp, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("cont_fp_resp", fp_ch_resp, 2'b01);
            tick();
            pmem_resp = 1'b0;
            settle();
            chk("cont_gap_resp", rr_ch_resp, 0);
            chk("cont_gap_read", rr_read,    0);
        end

        ch_read = 2'b00;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2, number of requesting cache channels, legal range 2..8.
REQ-002 Parameter ADDR_W, default 16, physical address width (lc3b_word).
REQ-003 Parameter LINE_W, default 128, line width (lc3b_line).
REQ-004 Parameter ARB_MODE, default 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-005 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-006 Port rst_n  input  1  asynchronous active-low reset.
REQ-007 Port ch_read  input  NUM_CH  per-channel line-read request.
REQ-008 Port ch_write  input  NUM_CH  per-channel line-write request.
REQ-009 Port ch_address  input  NUM_CH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 Port ch_wdata  input  NUM_CH*LINE_W  per-channel write line; same packing as ch_address.
REQ-011 Port ch_resp  output  NUM_CH  per-channel completion pulse.
REQ-012 Port ch_rdata  output  LINE_W  read line, broadcast to all channels.
REQ-013 Port pmem_read  output  1  physical memory read strobe.
REQ-014 Port pmem_write  output  1  physical memory write strobe.
REQ-015 Port pmem_address  output  ADDR_W  physical memory address.
REQ-016 Port pmem_wdata  output  LINE_W  physical memory write line.
REQ-017 Port pmem_resp  input  1  physical memory completion.
REQ-018 Port pmem_rdata  input  LINE_W  physical memory read line.

Function
REQ-019 FSM has exactly two states: IDLE and BUSY.
REQ-020 A channel requests when ch_read[i] | ch_write[i]; if both are high, the channel is serviced as a write.
REQ-021 In IDLE with at least one request, the arbiter selects a winner, latches winner index, op, address and wdata, and enters BUSY on the next edge.
REQ-022 Round-robin mode: search starts at (last_grant+1) mod NUM_CH and wraps; last_grant updates only on grant.
REQ-023 Fixed mode: lowest-index requesting channel wins; last_grant is ignored.
REQ-024 In BUSY, pmem_read/pmem_write, pmem_address and pmem_wdata are driven from latched registers only and are stable until pmem_resp.
REQ-025 ch_resp[g] = pmem_resp in BUSY for granted channel g only; all other bits 0; combinational, same cycle as pmem_resp.
REQ-026 ch_rdata = pmem_rdata at all times.
REQ-027 On pmem_resp in BUSY, FSM returns to IDLE on that edge; pmem_read/pmem_write deassert the following cycle.
REQ-028 Latency: request seen in IDLE at edge N -> pmem strobe high from edge N+1; minimum one IDLE cycle between back-to-back transactions.
REQ-029 Requester dropping its request while BUSY does not abort; transaction completes and ch_resp still pulses.
REQ-030 Requests arriving during BUSY are not latched; they are arbitrated in the next IDLE cycle.
REQ-031 pmem_resp in IDLE is ignored; no ch_resp pulses.
REQ-032 At most one of pmem_read, pmem_write is ever high.

Reset
REQ-033 rst_n low forces immediately, without clock: state IDLE, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, last_grant=NUM_CH-1 (so channel 0 has first priority).
REQ-034 ch_resp is 0 throughout reset; reset asserted mid-BUSY abandons the transaction with no ch_resp pulse.
REQ-035 First grant is evaluated on the first rising edge after rst_n deasserts.

Verification
REQ-036 Single read: NUM_CH=2, ch_read=2'b10, ch1 address 0x1230, pmem_resp after 3 cycles with rdata 0xDEAD..BEEF -> pmem_read high 3 cycles at 0x1230, ch_resp=2'b10 one cycle, ch_rdata=0xDEAD..BEEF.
REQ-037 Contention round-robin: both channels hold ch_read continuously from reset -> grant order 0,1,0,1; each ch_resp pulse exactly one cycle.
REQ-038 Fixed priority: ARB_MODE=1, both channels request continuously -> channel 0 serviced every transaction, channel 1 never granted.
REQ-039 Write with read: ch_write[0]=ch_read[0]=1, ch0 wdata 0xA5 repeated, address 0x0040 -> pmem_write=1, pmem_read=0, pmem_wdata=0xA5.., pmem_address=0x0040.
REQ-040 Reset mid-op: rst_n low while BUSY awaiting pmem_resp -> strobes 0 same cycle, no ch_resp; after release, ch0 and ch1 both requesting -> ch0 granted first.
REQ-041 Stability: change ch_address[0] during BUSY -> pmem_address holds the latched value until pmem_resp.
